uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART TX FIFO write port among NUM_REQ_p byte-stream requesters, e.g. the AXI-Lite register block, a debug/trace source and a DMA engine.
- Round-robin arbitration with message locking: a granted requester keeps the port until it writes its last byte or reaches MAX_BURST_p bytes.
- Sits between the requesters and the TX FIFO (o_tx_fifo_wr_en / o_tx_fifo_data / i_tx_fifo_full) and honours the TX FIFO clear.

Parameters:
- NUM_REQ_p, 4, number of requesters (2..8).
- MAX_BURST_p, 16, max bytes per grant before forced release (1..255).
- TIMEOUT_p, 64, idle cycles before a locked grant is dropped (used only with UART_TX_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_req_valid  in  NUM_REQ_p  per-requester byte valid.
- i_req_data  in  8*NUM_REQ_p  per-requester byte; requester k uses bits [8k+7:8k].
- i_req_last  in  NUM_REQ_p  byte is last of message.
- o_req_ready  out  NUM_REQ_p  byte accepted when valid&ready.
- i_tx_fifo_full  in  1  TX FIFO full.
- i_clr_tx_fifo  in  1  TX FIFO clear (same pulse driven to the FIFO).
- o_tx_fifo_wr_en  out  1  FIFO write strobe.
- o_tx_fifo_data  out  8  FIFO write data.
- o_grant_id  out  $clog2(NUM_REQ_p)  current or last granted index.
- o_busy  out  1  state is LOCKED.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rr pointer 0; burst count 0; o_grant_id 0; o_busy 0; o_req_ready 0; o_tx_fifo_wr_en 0; o_tx_fifo_data 0.
- FSM states: IDLE, LOCKED.
- IDLE:
  - Any i_req_valid set and i_clr_tx_fifo=0: pick the first valid index searching from rr pointer upward, wrapping modulo NUM_REQ_p.
  - Register it as grant; go to LOCKED next cycle; burst count <= 0.
  - No byte is transferred in the arbitration cycle, so arbitration latency is 1 cycle.
- LOCKED:
  - o_req_ready[g] = !i_tx_fifo_full & !i_clr_tx_fifo. All other ready bits are 0.
  - Write path is combinational: o_tx_fifo_wr_en = i_req_valid[g] & o_req_ready[g]; o_tx_fifo_data = i_req_data[g]. Data is 0 when not writing.
  - Each accepted byte increments burst count (8-bit, saturating; it cannot wrap because release precedes overflow).
- Release (LOCKED -> IDLE), on an accepted byte with i_req_last[g]=1 or burst count+1 == MAX_BURST_p:
  - rr pointer <= g+1 mod NUM_REQ_p.
  - The released requester cannot be regranted in the following IDLE cycle if another valid exists.
- i_clr_tx_fifo=1 in any state:
  - No write, all ready 0.
  - Next state IDLE, burst count 0, rr pointer <= g+1 (grant aborted).
- i_tx_fifo_full while LOCKED: stall, hold grant, burst count unchanged. Not a release condition.
- Valid drops while LOCKED: grant is held (message lock) unless timeout applies.
- Simultaneous last byte and new requests: release takes effect; the next grant happens in the following IDLE cycle.
- o_grant_id holds the last grant in IDLE. o_busy = (state==LOCKED).
- Reset mid-message: immediate return to reset values. Partial message bytes already in the FIFO are not retracted.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined: an idle counter counts consecutive LOCKED cycles with i_req_valid[g]=0 and i_tx_fifo_full=0. It resets on any accepted byte or on leaving LOCKED.
  - When it reaches TIMEOUT_p, force release (rr pointer advances) next cycle.
  - Counter width is $clog2(TIMEOUT_p+1).
- Undefined: no counter logic; a locked requester holds the port indefinitely until last/MAX_BURST_p/clear.

Test Plan:
- Single requester: req1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), FIFO not full -> wr_en pulses on cycles 1,2,3 after arbitration with the same data; o_grant_id=1; IDLE after 0x43.
- Fairness: req0 and req2 both continuously valid, 2-byte messages -> grant order 0,2,0,2; no requester is granted twice in a row.
- MAX_BURST_p=4: req3 sends 10 bytes with no last while req0 is pending -> req3 gets 4 bytes, req0 gets its message, then req3 resumes.
- Backpressure: i_tx_fifo_full=1 for 5 cycles mid-message -> wr_en=0 and ready=0 throughout, grant held, all bytes delivered in order after full deasserts.
- Clear: i_clr_tx_fifo pulses while req1 is locked after 2 of 5 bytes -> no write that cycle, IDLE next, rr pointer=2; a pending req2 is granted next.
- Timeout (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_p=8): req0 locked, drops valid for 8 cycles -> release; pending req1 granted; without the macro, req1 stays waiting.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one UART TX FIFO write port among NUM_REQ_p byte streams.
// Optional locked-grant idle timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ_p   = 4,
  parameter int MAX_BURST_p = 16,
  parameter int TIMEOUT_p   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ_p-1:0]         i_req_valid,
  input  logic [8*NUM_REQ_p-1:0]       i_req_data,
  input  logic [NUM_REQ_p-1:0]         i_req_last,
  output logic [NUM_REQ_p-1:0]         o_req_ready,
  input  logic                         i_tx_fifo_full,
  input  logic                         i_clr_tx_fifo,
  output logic                         o_tx_fifo_wr_en,
  output logic [7:0]                   o_tx_fifo_data,
  output logic [$clog2(NUM_REQ_p)-1:0] o_grant_id,
  output logic                         o_busy
);

  localparam int GW = $clog2(NUM_REQ_p);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [7:0]      burst_cnt_reg, burst_cnt_next;

  logic [7:0]      req_bytes [NUM_REQ_p];
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic            locked_ready;
  logic            timeout_hit;
  logic [GW-1:0]   grant_inc;

  logic [2*NUM_REQ_p-1:0] valid_dbl;
  logic [NUM_REQ_p-1:0]   valid_rot;
  logic [GW-1:0]          pick_off;
  logic [GW:0]            pick_sum;
  logic [GW-1:0]          pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ_p; gi++) begin : g_req
      assign req_bytes[gi]   = i_req_data[8*gi +: 8];
      assign o_req_ready[gi] = locked_ready && (grant_reg == GW'(gi));
    end
  endgenerate

  assign g_valid   = i_req_valid[grant_reg];
  assign g_last    = i_req_last[grant_reg];
  assign g_data    = req_bytes[grant_reg];
  assign grant_inc = (grant_reg == GW'(NUM_REQ_p - 1)) ? '0 : grant_reg + 1'b1;

  // Rotate the valid vector so bit 0 is the rr pointer, then take the lowest set bit.
  assign valid_dbl = {i_req_valid, i_req_valid} >> rr_ptr_reg;
  assign valid_rot = valid_dbl[NUM_REQ_p-1:0];

  always_comb begin
    pick_off = '0;
    for (int i = NUM_REQ_p - 1; i >= 0; i--) begin
      if (valid_rot[i]) pick_off = GW'(i);
    end
  end

  assign pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= (GW+1)'(NUM_REQ_p)) ? GW'(pick_sum - (GW+1)'(NUM_REQ_p))
                                                      : GW'(pick_sum);

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    locked_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_clr_tx_fifo) begin
          rr_ptr_next = grant_inc;
        end else if (|i_req_valid) begin
          grant_next     = pick_idx;
          state_next     = LOCKED;
          burst_cnt_next = '0;
        end
      end
      LOCKED: begin
        if (i_clr_tx_fifo || timeout_hit) begin
          state_next     = IDLE;
          burst_cnt_next = '0;
          rr_ptr_next    = grant_inc;
        end else begin
          locked_ready = !i_tx_fifo_full;
          if (g_valid && locked_ready) begin
            // Release on the last byte or on the byte that fills the burst quota.
            if (g_last || (burst_cnt_reg == 8'(MAX_BURST_p - 1))) begin
              state_next     = IDLE;
              burst_cnt_next = '0;
              rr_ptr_next    = grant_inc;
            end else if (burst_cnt_reg != 8'hFF) begin
              burst_cnt_next = burst_cnt_reg + 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_tx_fifo_wr_en = g_valid && locked_ready;
  assign o_tx_fifo_data  = o_tx_fifo_wr_en ? g_data : 8'h00;
  assign o_grant_id      = grant_reg;
  assign o_busy          = (state_reg == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_p + 1);

  logic [TW-1:0] idle_cnt_reg, idle_cnt_next;

  // Counting saturates at TIMEOUT_p; the cycle that sees it saturated performs the release.
  assign timeout_hit = (state_reg == LOCKED) && (idle_cnt_reg == TW'(TIMEOUT_p));

  always_comb begin
    idle_cnt_next = '0;
    if ((state_reg == LOCKED) && (state_next == LOCKED) && !o_tx_fifo_wr_en) begin
      if (!g_valid && !i_tx_fifo_full && (idle_cnt_reg != TW'(TIMEOUT_p))) begin
        idle_cnt_next = idle_cnt_reg + 1'b1;
      end else begin
        idle_cnt_next = idle_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, write log compared against hand-built expectations.
// DUT built with NUM_REQ_p=4, MAX_BURST_p=4, TIMEOUT_p=8.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_fifo_full;
  logic        clr_tx_fifo;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests;
  int n_fail;

  logic [8:0]  rq [4][$];
  logic [3:0]  gate;
  logic [15:0] wr_log [$];
  logic [15:0] exp_log [$];

  logic        s_wr;
  logic [7:0]  s_data;
  logic [1:0]  s_gid;
  logic        s_busy;
  logic [3:0]  s_ready;

  uart_tx_arbiter #(
    .NUM_REQ_p  (4),
    .MAX_BURST_p(4),
    .TIMEOUT_p  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .i_tx_fifo_full (tx_fifo_full),
    .i_clr_tx_fifo  (clr_tx_fifo),
    .o_tx_fifo_wr_en(tx_fifo_wr_en),
    .o_tx_fifo_data (tx_fifo_data),
    .o_grant_id     (grant_id),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [8:0] head;
    for (int k = 0; k < 4; k++) begin
      if (gate[k] && rq[k].size() > 0) begin
        head             = rq[k][0];
        req_valid[k]     = 1'b1;
        req_data[8*k +: 8] = head[7:0];
        req_last[k]      = head[8];
      end else begin
        req_valid[k]     = 1'b0;
        req_data[8*k +: 8] = 8'h00;
        req_last[k]      = 1'b0;
      end
    end
  endtask

  // One clock: drive after the rising edge, sample on the falling edge.
  task automatic tick();
    drive_inputs();
    @(negedge clk);
    s_wr    = tx_fifo_wr_en;
    s_data  = tx_fifo_data;
    s_gid   = grant_id;
    s_busy  = busy;
    s_ready = req_ready;
    if (s_wr) begin
      wr_log.push_back({6'd0, s_gid, s_data});
      $display("[TB] write gid=%0d data=%02h t=%0t", s_gid, s_data, $time);
    end
    for (int k = 0; k < 4; k++) begin
      if (req_valid[k] && req_ready[k]) void'(rq[k].pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 4; k++) rq[k].delete();
    wr_log.delete();
    exp_log.delete();
    gate         = 4'hF;
    tx_fifo_full = 1'b0;
    clr_tx_fifo  = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    rst_n        = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
    check("rst_wr", tx_fifo_wr_en, 0);
    check("rst_ready", req_ready, 0);
    check("rst_data", tx_fifo_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic last);
    rq[k].push_back({last, d});
  endtask

  task automatic expect_wr(input logic [1:0] gid, input logic [7:0] d);
    exp_log.push_back({6'd0, gid, d});
  endtask

  task automatic drain(input string tag);
    int budget;
    int left;
    budget = 200;
    left   = rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size();
    while (left > 0 && budget > 0) begin
      tick();
      budget--;
      left = rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size();
    end
    check({tag, "_drain_left"}, left, 0);
  endtask

  task automatic check_log(input string tag);
    int n;
    check({tag, "_log_len"}, wr_log.size(), exp_log.size());
    n = (wr_log.size() < exp_log.size()) ? wr_log.size() : exp_log.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_log%0d", tag, i), wr_log[i], exp_log[i]);
    end
  endtask

  logic b8, b9;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    gate    = 4'hF;
    @(posedge clk);
    #1;

    // Single requester: one arbitration cycle then three back-to-back writes.
    do_reset();
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b0);
    push(1, 8'h43, 1'b1);
    tick();
    check("t1_arb_wr", s_wr, 0);
    check("t1_arb_busy", s_busy, 0);
    tick();
    check("t1_b0_wr", s_wr, 1);
    check("t1_b0_data", s_data, 8'h41);
    check("t1_b0_gid", s_gid, 1);
    check("t1_b0_ready", s_ready, 4'b0010);
    tick();
    check("t1_b1_data", s_data, 8'h42);
    tick();
    check("t1_b2_wr", s_wr, 1);
    check("t1_b2_data", s_data, 8'h43);
    tick();
    check("t1_end_busy", s_busy, 0);
    check("t1_end_wr", s_wr, 0);
    check("t1_end_gid", s_gid, 1);

    // Fairness: two 2-byte messages each from req0 and req2.
    do_reset();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b1);
    expect_wr(0, 8'hA0); expect_wr(0, 8'hA1);
    expect_wr(2, 8'hC0); expect_wr(2, 8'hC1);
    expect_wr(0, 8'hA2); expect_wr(0, 8'hA3);
    expect_wr(2, 8'hC2); expect_wr(2, 8'hC3);
    drain("t2");
    check_log("t2");

    // Burst limit of 4: req3 streams 10 bytes with no last while req0 has a message.
    do_reset();
    for (int i = 0; i < 10; i++) push(3, 8'(8'h30 + i), 1'b0);
    tick();
    push(0, 8'hB0, 1'b0);
    push(0, 8'hB1, 1'b1);
    for (int i = 0; i < 4; i++) expect_wr(3, 8'(8'h30 + i));
    expect_wr(0, 8'hB0); expect_wr(0, 8'hB1);
    for (int i = 4; i < 10; i++) expect_wr(3, 8'(8'h30 + i));
    drain("t3");
    check_log("t3");

    // Backpressure: FIFO full for 5 cycles after the first byte.
    do_reset();
    push(1, 8'h51, 1'b0);
    push(1, 8'h52, 1'b0);
    push(1, 8'h53, 1'b1);
    tick();
    tick();
    tx_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4_full%0d_wr", i), s_wr, 0);
      check($sformatf("t4_full%0d_ready", i), s_ready, 0);
      check($sformatf("t4_full%0d_gid", i), {s_busy, s_gid}, 3'b101);
    end
    tx_fifo_full = 1'b0;
    expect_wr(1, 8'h51); expect_wr(1, 8'h52); expect_wr(1, 8'h53);
    drain("t4");
    check_log("t4");

    // Clear after 2 of 5 bytes from req1; req2 pending must be granted next.
    do_reset();
    for (int i = 1; i <= 5; i++) push(1, 8'(8'h60 + i), i == 5);
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b1);
    tick();
    tick();
    tick();
    clr_tx_fifo = 1'b1;
    tick();
    check("t5_clr_wr", s_wr, 0);
    check("t5_clr_ready", s_ready, 0);
    clr_tx_fifo = 1'b0;
    tick();
    check("t5_after_busy", s_busy, 0);
    tick();
    check("t5_regrant_gid", s_gid, 2);
    check("t5_regrant_data", s_data, 8'h71);
    expect_wr(1, 8'h61); expect_wr(1, 8'h62);
    expect_wr(2, 8'h71); expect_wr(2, 8'h72);
    expect_wr(1, 8'h63); expect_wr(1, 8'h64); expect_wr(1, 8'h65);
    drain("t5");
    check_log("t5");

    // Locked req0 goes silent for 12 cycles while req1 waits.
    do_reset();
    push(0, 8'h81, 1'b0);
    push(0, 8'h82, 1'b0);
    push(0, 8'h83, 1'b1);
    tick();
    tick();
    gate[0] = 1'b0;
    push(1, 8'h91, 1'b1);
    b8 = 1'b0;
    b9 = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (t == 8) b8 = s_busy;
      if (t == 9) b9 = s_busy;
    end
    check("t6_busy_t8", b8, 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("t6_busy_t9", b9, 0);
    check("t6_mid_log_len", wr_log.size(), 2);
    expect_wr(0, 8'h81); expect_wr(1, 8'h91);
    expect_wr(0, 8'h82); expect_wr(0, 8'h83);
`else
    check("t6_busy_t9", b9, 1);
    check("t6_mid_log_len", wr_log.size(), 1);
    expect_wr(0, 8'h81); expect_wr(0, 8'h82);
    expect_wr(0, 8'h83); expect_wr(1, 8'h91);
`endif
    gate[0] = 1'b1;
    drain("t6");
    check_log("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
